multiple_transfer_sequencer: RTL



---
 rtl/multiple_transfer_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multiple_transfer_sequencer.sv
// rtl/multiple_transfer_sequencer.sv - load/store-multiple sequencer; optional MTS_ALIGN_CHECK_EN flags misaligned base
module multiple_transfer_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              p,
    input  logic              u,
    input  logic              l,
    input  logic              w,
    input  logic              mem_ready,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        reg_addr,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_value,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] C_FOUR = {{(ADDR_W-3){1'b0}}, 3'b100};

    state_t            r_state;
    logic [15:0]       r_mask;
    logic [ADDR_W-1:0] r_base;
    logic              r_p;
    logic              r_u;
    logic              r_l;
    logic              r_w;
    logic              r_busy;
    logic              r_mem_req;
    logic              r_mem_rw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_reg_addr;
    logic              r_wb_en;
    logic [ADDR_W-1:0] r_wb_value;
    logic              r_done;
    logic              r_err;

    logic [4:0]        w_n;
    logic [ADDR_W-1:0] w_four_n;
    logic [ADDR_W-1:0] w_start_addr;
    logic [ADDR_W-1:0] w_wb_value;
    logic [15:0]       w_mask_next;
    logic [3:0]        w_first_reg;
    logic [3:0]        w_next_reg;
    logic              w_misaligned;

    // Lowest set bit of a register mask; zero for an empty mask.
    function automatic logic [3:0] f_lowest(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Number of registers in the latched list (0..16).
    always_comb begin
        w_n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_n = w_n + {4'd0, r_mask[i]};
        end
    end

    // Start address and writeback value for the four addressing modes.
    always_comb begin
        w_four_n   = {{(ADDR_W-7){1'b0}}, w_n, 2'b00};
        w_wb_value = r_u ? (r_base + w_four_n) : (r_base - w_four_n);
        case ({r_p, r_u})
            2'b01:   w_start_addr = r_base;
            2'b11:   w_start_addr = r_base + C_FOUR;
            2'b00:   w_start_addr = r_base - w_four_n + C_FOUR;
            default: w_start_addr = r_base - w_four_n;
        endcase
    end

    assign w_mask_next = r_mask & (r_mask - 16'd1);
    assign w_first_reg = f_lowest(r_mask);
    assign w_next_reg  = f_lowest(w_mask_next);

`ifdef MTS_ALIGN_CHECK_EN
    logic r_misaligned;

    // Remember whether the sampled base had non-zero low bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_misaligned <= |base_addr[1:0];
        end
    end

    assign w_misaligned = r_misaligned && (w_n != 5'd0);
`else
    // Low base bits are dropped; addresses are always word aligned.
    logic w_unused_base_lsb;
    assign w_unused_base_lsb = ^base_addr[1:0];
    assign w_misaligned      = 1'b0;
`endif

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mask     <= 16'd0;
            r_base     <= '0;
            r_p        <= 1'b0;
            r_u        <= 1'b0;
            r_l        <= 1'b0;
            r_w        <= 1'b0;
            r_busy     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_rw   <= 1'b0;
            r_mem_addr <= '0;
            r_reg_addr <= 4'd0;
            r_wb_en    <= 1'b0;
            r_wb_value <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mask  <= reg_list;
                        r_base  <= {base_addr[ADDR_W-1:2], 2'b00};
                        r_p     <= p;
                        r_u     <= u;
                        r_l     <= l;
                        r_w     <= w;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_wb_value <= w_wb_value;
                    if (w_n == 5'd0 || w_misaligned) begin
                        r_err   <= w_misaligned;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_rw   <= r_l;
                        r_mem_addr <= w_start_addr;
                        r_reg_addr <= w_first_reg;
                        r_state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (mem_ready) begin
                        r_mask     <= w_mask_next;
                        r_mem_addr <= r_mem_addr + C_FOUR;
                        if (w_mask_next == 16'd0) begin
                            r_mem_req <= 1'b0;
                            r_mem_rw  <= 1'b0;
                            if (r_w) begin
                                r_wb_en <= 1'b1;
                                r_state <= S_WB;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_reg_addr <= w_next_reg;
                        end
                    end
                end
                S_WB: begin
                    r_wb_en <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign mem_req  = r_mem_req;
    assign mem_rw   = r_mem_rw;
    assign mem_addr = r_mem_addr;
    assign reg_addr = r_reg_addr;
    assign wb_en    = r_wb_en;
    assign wb_value = r_wb_value;
    assign done     = r_done;
    assign err      = r_err;

endmodule
